// File: rtl/game_pkg.sv
// Shared game definitions: stage encoding and default tuning constants
// used by the stage sequencer and the fighter blocks.
package game_pkg;

    typedef enum logic [1:0] {
        STG_START,
        STG_BATTLE,
        STG_WIN,
        STG_LOSE
    } stage_t;

    localparam int HP_W_DEF        = 8;
    localparam int HP_MAX_DEF      = 100;
    localparam int HIT_DMG_DEF     = 10;
    localparam int START_HOLD_DEF  = 60;
    localparam int RESULT_HOLD_DEF = 180;
    localparam int FRM_W_DEF       = 8;

endpackage

// File: rtl/edge_detect.sv
// Single-bit rising-edge pulse generator for an already
// synchronised level input.
module edge_detect (
    input  logic Clk,
    input  logic d,
    output logic pulse
);

    logic d_q;

    // The flop tracks the level in every cycle, reset included,
    // so no spurious edge appears right after reset.
    always_ff @(posedge Clk) begin
        d_q <= d;
    end

    assign pulse = d & ~d_q;

endmodule

// File: rtl/game_stage_ctrl.sv
// Stage sequencer: title, battle, win and lose screens, fighter HP
// tracking and the per-battle game_reset pulse.
module game_stage_ctrl
    import game_pkg::*;
#(
    parameter int HP_W               = HP_W_DEF,
    parameter int HP_MAX             = HP_MAX_DEF,
    parameter int HIT_DMG            = HIT_DMG_DEF,
    parameter int START_HOLD_FRAMES  = START_HOLD_DEF,
    parameter int RESULT_HOLD_FRAMES = RESULT_HOLD_DEF,
    parameter int FRM_W              = FRM_W_DEF
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            frame_clk,
    input  logic            start_key,
    input  logic            player_hit,
    input  logic            npc_hit,
    output logic            start_l,
    output logic            battle_l,
    output logic            win_l,
    output logic            lose_l,
    output logic [HP_W-1:0] player_hp,
    output logic [HP_W-1:0] npc_hp,
    output logic            game_reset
);

    localparam logic [HP_W-1:0]  HP_FULL     = HP_W'(HP_MAX);
    localparam logic [HP_W-1:0]  DMG         = HP_W'(HIT_DMG);
    localparam logic [FRM_W-1:0] START_HOLD  = FRM_W'(START_HOLD_FRAMES);
    localparam logic [FRM_W-1:0] RESULT_HOLD = FRM_W'(RESULT_HOLD_FRAMES);

    logic             frame_tick;
    logic             key_press;
    logic             start_ok;
    stage_t           state;
    stage_t           state_d;
    logic [FRM_W-1:0] frm_cnt;

    function automatic logic [HP_W-1:0] hit(input logic [HP_W-1:0] hp);
        return (hp < DMG) ? '0 : hp - DMG;
    endfunction

    edge_detect u_frame_edge (
        .Clk   (Clk),
        .d     (frame_clk),
        .pulse (frame_tick)
    );

    edge_detect u_key_edge (
        .Clk   (Clk),
        .d     (start_key),
        .pulse (key_press)
    );

    assign start_ok = key_press && (frm_cnt == START_HOLD);

    // Battle exit looks at registered HP, one cycle after the hit.
    always_comb begin
        state_d = STG_START;
        case (state)
            STG_START:  state_d = start_ok ? STG_BATTLE : STG_START;
            STG_BATTLE: begin
                if (player_hp == '0)   state_d = STG_LOSE;
                else if (npc_hp == '0) state_d = STG_WIN;
                else                   state_d = STG_BATTLE;
            end
            STG_WIN,
            STG_LOSE:   state_d = (frm_cnt == RESULT_HOLD) ? STG_START : state;
            default:    state_d = STG_START;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state      <= STG_START;
            start_l    <= 1'b1;
            battle_l   <= 1'b0;
            win_l      <= 1'b0;
            lose_l     <= 1'b0;
            player_hp  <= HP_FULL;
            npc_hp     <= HP_FULL;
            frm_cnt    <= '0;
            game_reset <= 1'b0;
        end else begin
            state      <= state_d;
            start_l    <= (state_d == STG_START);
            battle_l   <= (state_d == STG_BATTLE);
            win_l      <= (state_d == STG_WIN);
            lose_l     <= (state_d == STG_LOSE);
            game_reset <= (state == STG_START) && start_ok;
            case (state)
                STG_START: begin
                    if (start_ok) begin
                        player_hp <= HP_FULL;
                        npc_hp    <= HP_FULL;
                        frm_cnt   <= '0;
                    end else if (frame_tick && frm_cnt < START_HOLD) begin
                        frm_cnt <= frm_cnt + FRM_W'(1);
                    end
                end
                STG_BATTLE: begin
                    if (player_hit) player_hp <= hit(player_hp);
                    if (npc_hit)    npc_hp    <= hit(npc_hp);
                    if (state_d != STG_BATTLE) frm_cnt <= '0;
                end
                STG_WIN,
                STG_LOSE: begin
                    if (state_d == STG_START) frm_cnt <= '0;
                    else if (frame_tick)      frm_cnt <= frm_cnt + FRM_W'(1);
                end
                default: frm_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_game_stage_ctrl.sv
// Bench for game_stage_ctrl: two instances (hit damage 10 and 30)
// compared each cycle against a behavioural game model.
module tb_game_stage_ctrl;

    localparam int HP_MAX      = 100;
    localparam int START_HOLD  = 60;
    localparam int RESULT_HOLD = 180;
    localparam int TITLE = 0, FIGHT = 1, VICTORY = 2, DEFEAT = 3;

    logic clk = 1'b0;
    logic rst_n, frame_clk, start_key, player_hit, npc_hit;

    logic [1:0]      s_l, b_l, w_l, l_l, grst;
    logic [1:0][7:0] php, nhp;

    int checks = 0;
    int errors = 0;
    int grst_cnt = 0;

    int dmg [2] = '{10, 30};
    int m_stg [2], m_php [2], m_nhp [2], m_cnt [2], m_grst [2];
    bit m_pf [2], m_pk [2];

    always #5 clk = ~clk;

    game_stage_ctrl dut (
        .Clk(clk), .Reset_n(rst_n), .frame_clk(frame_clk),
        .start_key(start_key), .player_hit(player_hit), .npc_hit(npc_hit),
        .start_l(s_l[0]), .battle_l(b_l[0]), .win_l(w_l[0]), .lose_l(l_l[0]),
        .player_hp(php[0]), .npc_hp(nhp[0]), .game_reset(grst[0])
    );

    game_stage_ctrl #(.HIT_DMG(30)) dut30 (
        .Clk(clk), .Reset_n(rst_n), .frame_clk(frame_clk),
        .start_key(start_key), .player_hit(player_hit), .npc_hit(npc_hit),
        .start_l(s_l[1]), .battle_l(b_l[1]), .win_l(w_l[1]), .lose_l(l_l[1]),
        .player_hp(php[1]), .npc_hp(nhp[1]), .game_reset(grst[1])
    );

    task automatic chk(string tag, int i, logic [31:0] act, int exp);
        checks++;
        assert (act === 32'(exp)) else begin
            errors++;
            $error("FAIL %s[%0d] @%0t: got %0d expected %0d",
                   tag, i, $time, act, exp);
        end
    endtask

    // One clock of the game as the players see it.
    task automatic model_step();
        bit fe, ke;
        int p, n;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_stg[i] = TITLE;
                m_php[i] = HP_MAX;
                m_nhp[i] = HP_MAX;
                m_cnt[i] = 0;
                m_grst[i] = 0;
            end else begin
                fe = frame_clk && !m_pf[i];
                ke = start_key && !m_pk[i];
                m_grst[i] = 0;
                case (m_stg[i])
                    TITLE: begin
                        if (ke && m_cnt[i] == START_HOLD) begin
                            m_stg[i] = FIGHT;
                            m_php[i] = HP_MAX;
                            m_nhp[i] = HP_MAX;
                            m_cnt[i] = 0;
                            m_grst[i] = 1;
                        end else if (fe && m_cnt[i] < START_HOLD) begin
                            m_cnt[i]++;
                        end
                    end
                    FIGHT: begin
                        p = m_php[i];
                        n = m_nhp[i];
                        if (player_hit) m_php[i] = (p >= dmg[i]) ? p - dmg[i] : 0;
                        if (npc_hit)    m_nhp[i] = (n >= dmg[i]) ? n - dmg[i] : 0;
                        if (p == 0) begin
                            m_stg[i] = DEFEAT;
                            m_cnt[i] = 0;
                        end else if (n == 0) begin
                            m_stg[i] = VICTORY;
                            m_cnt[i] = 0;
                        end
                    end
                    default: begin
                        if (m_cnt[i] == RESULT_HOLD) begin
                            m_stg[i] = TITLE;
                            m_cnt[i] = 0;
                        end else if (fe) begin
                            m_cnt[i]++;
                        end
                    end
                endcase
            end
            m_pf[i] = frame_clk;
            m_pk[i] = start_key;
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            chk("start_l",    i, s_l[i],  m_stg[i] == TITLE);
            chk("battle_l",   i, b_l[i],  m_stg[i] == FIGHT);
            chk("win_l",      i, w_l[i],  m_stg[i] == VICTORY);
            chk("lose_l",     i, l_l[i],  m_stg[i] == DEFEAT);
            chk("player_hp",  i, php[i],  m_php[i]);
            chk("npc_hp",     i, nhp[i],  m_nhp[i]);
            chk("game_reset", i, grst[i], m_grst[i]);
        end
    endtask

    task automatic cycle(bit f, bit ph, bit nh);
        frame_clk  = f;
        player_hit = ph;
        npc_hit    = nh;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
        if (grst[0] === 1'b1) grst_cnt++;
    endtask

    task automatic frames(int n);
        repeat (n) begin
            cycle(1, 0, 0);
            cycle(0, 0, 0);
        end
    endtask

    task automatic press();
        start_key = 1'b1;
        cycle(0, 0, 0);
        start_key = 1'b0;
        cycle(0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start_key = 1'b0;
        repeat (2) cycle(0, 0, 0);
        rst_n = 1'b1;
        chk("reset_start_l", 0, s_l[0], 1);
        chk("reset_hp", 0, php[0], HP_MAX);

        frames(10);
        press();
        chk("early_press_ignored", 0, s_l[0], 1);

        frames(50);
        grst_cnt = 0;
        start_key = 1'b1;
        repeat (3) cycle(0, 0, 0);
        chk("battle_after_hold", 0, b_l[0], 1);

        repeat (10) begin
            cycle(0, 0, 1);
            cycle(0, 0, 0);
        end
        cycle(0, 0, 0);
        chk("win_after_ko", 0, w_l[0], 1);
        chk("player_hp_kept", 0, php[0], HP_MAX);
        frames(200);
        chk("single_game_reset", 0, grst_cnt, 1);
        chk("back_to_title", 0, s_l[0], 1);
        start_key = 1'b0;
        cycle(0, 0, 0);

        frames(60);
        press();
        repeat (4) begin
            cycle(0, 1, 0);
            cycle(0, 0, 0);
        end
        chk("lose30_sat_hp", 1, php[1], 0);
        chk("lose30_stage", 1, l_l[1], 1);
        repeat (5) begin
            cycle(0, 1, 0);
            cycle(0, 0, 0);
        end
        repeat (9) begin
            cycle(0, 0, 1);
            cycle(0, 0, 0);
        end
        cycle(0, 1, 1);
        cycle(0, 0, 0);
        chk("double_ko_lose", 0, l_l[0], 1);
        chk("double_ko_win", 0, w_l[0], 0);
        repeat (3) begin
            cycle(0, 1, 1);
            cycle(0, 0, 0);
        end
        chk("frozen_npc_hp", 0, nhp[0], 0);

        frames(250);
        press();
        repeat (5) begin
            cycle(0, 0, 1);
            cycle(0, 0, 0);
        end
        chk("mid_battle_npc_hp", 0, nhp[0], 50);
        rst_n = 1'b0;
        cycle(0, 0, 0);
        rst_n = 1'b1;
        chk("mid_reset_start", 0, s_l[0], 1);
        chk("mid_reset_hp", 0, nhp[0], HP_MAX);
        frames(59);
        press();
        chk("hold_restarted", 0, s_l[0], 1);
        frames(1);
        press();
        chk("battle_after_reset", 0, b_l[0], 1);

        repeat (4000) begin
            rst_n = ($urandom_range(0, 999) != 0);
            if ($urandom_range(0, 99) < 4) start_key = ~start_key;
            cycle(($urandom_range(0, 99) < 50),
                  ($urandom_range(0, 99) < 8),
                  ($urandom_range(0, 99) < 8));
        end
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
